bound_flasher_param: RTL and testbench

Parametrised successor to the fixed 16-LED bound flasher. The block drives an N-lamp bar through the ramp sequence: up to full, down to a low bound, up to a mid bound, down to zero, up to full, then down to zero. The sequence starts on flick. A flick at a kickback point during an up-to-full ramp sends the bar back down to zero, after which the interrupted ramp restarts. New relative to the fixed block: configurable lamp count, bounds and step rate; a runtime mirror mode; a kickback counter. The block sits at top level, driving the LED bar directly.

---
 rtl/bound_flasher_pkg.sv | 36 +++
 rtl/bound_flasher_param_tick_gen.sv | 24 ++
 rtl/bound_flasher_param.sv | 162 ++++++++++++++++
 tb/tb_bound_flasher_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and helpers for the parametrised bound flasher.
// Provides the FSM state encoding, counter width and the bar decoder.
package bound_flasher_pkg;

  localparam int KICK_CNT_W = 8;
  localparam int BAR_MAX    = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UP_FULL   = 3'd1,
    DOWN_LOW  = 3'd2,
    UP_MID    = 3'd3,
    DOWN_ZERO = 3'd4,
    UP_FULL2  = 3'd5,
    DOWN_END  = 3'd6,
    KICK      = 3'd7
  } bf_state_t;

  // Lit count to lamp bar; only the low n bits are meaningful.
  function automatic logic [BAR_MAX-1:0] lit_to_bar(
    input logic [6:0] lit,
    input logic       mir,
    input int         n
  );
    logic [BAR_MAX-1:0] bar;
    bar = '0;
    for (int i = 0; i < BAR_MAX; i++) begin
      if (i < n && i < int'(lit)) begin
        if (mir) bar[6'(n-1-i)] = 1'b1;
        else     bar[6'(i)]     = 1'b1;
      end
    end
    return bar;
  endfunction

endpackage

// File: rtl/bound_flasher_param_tick_gen.sv
// Step-rate prescaler: tick_o is high once every TICK_DIV clocks.
// Ports: clk_i, rst_ni (async active-low), tick_o.
module bf_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: ramps an N_LED lamp bar with kickback.
// Ports: clk, reset (async low), flick, mirror -> LED, current_state,
// current_index, kick_count. Macro BF_FLICK_EDGE_EN: edge-detect flick.
module bound_flasher_param
  import bound_flasher_pkg::*;
#(
  parameter int N_LED     = 16,
  parameter int LOW_BOUND = 5,
  parameter int MID_BOUND = 11,
  parameter int KICK_LO   = 6,
  parameter int KICK_HI   = 11,
  parameter int TICK_DIV  = 1,
  localparam int IW = $clog2(N_LED + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flick,
  input  logic                  mirror,
  output logic [N_LED-1:0]      LED,
  output logic [2:0]            current_state,
  output logic [IW-1:0]         current_index,
  output logic [KICK_CNT_W-1:0] kick_count
);

  if (!(N_LED >= 4 && N_LED <= 64 &&
        LOW_BOUND > 0 && LOW_BOUND < MID_BOUND &&
        MID_BOUND <= N_LED && KICK_LO < KICK_HI &&
        KICK_HI <= N_LED && TICK_DIV >= 1)) begin : g_bad_params
    $error("bound_flasher_param: illegal parameters");
  end

  localparam logic [IW-1:0] L_FULL    = IW'(N_LED);
  localparam logic [IW-1:0] L_FULL_M1 = IW'(N_LED - 1);
  localparam logic [IW-1:0] L_LOW     = IW'(LOW_BOUND);
  localparam logic [IW-1:0] L_LOW_P1  = IW'(LOW_BOUND + 1);
  localparam logic [IW-1:0] L_MID     = IW'(MID_BOUND);
  localparam logic [IW-1:0] L_MID_M1  = IW'(MID_BOUND - 1);
  localparam logic [IW-1:0] L_KLO     = IW'(KICK_LO);
  localparam logic [IW-1:0] L_KHI     = IW'(KICK_HI);
  localparam logic [IW-1:0] L_ONE     = IW'(1);

  logic tick;
  logic flick_s;

  bf_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

`ifdef BF_FLICK_EDGE_EN
  logic flick_q, flick_qq, sticky_q, flick_rise;

  assign flick_rise = flick_q & ~flick_qq;
  // A rise waits here until a tick consumes it.
  assign flick_s    = sticky_q | flick_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flick_q  <= 1'b0;
      flick_qq <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      flick_q  <= flick;
      flick_qq <= flick_q;
      sticky_q <= tick ? 1'b0 : flick_s;
    end
  end
`else
  assign flick_s = flick;
`endif

  bf_state_t             state_q, state_d;
  bf_state_t             ret_q, ret_d;
  logic [IW-1:0]         lit_q, lit_d;
  logic [KICK_CNT_W-1:0] kick_q, kick_d;
  logic                  kick_pt;

  assign kick_pt = (lit_q == L_KLO) || (lit_q == L_KHI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ret_q   <= UP_FULL;
      lit_q   <= '0;
      kick_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      lit_q   <= lit_d;
      kick_q  <= kick_d;
    end
  end

  // Ramps clamp to their target, so the reaching edge also moves state.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    lit_d   = lit_q;
    kick_d  = kick_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (flick_s) state_d = UP_FULL;
        end
        UP_FULL, UP_FULL2: begin
          if (flick_s && kick_pt) begin
            state_d = KICK;
            ret_d   = state_q;
            if (kick_q != '1) kick_d = kick_q + 1'b1;
          end else if (lit_q >= L_FULL_M1) begin
            lit_d   = L_FULL;
            state_d = (state_q == UP_FULL) ? DOWN_LOW : DOWN_END;
          end else begin
            lit_d = lit_q + 1'b1;
          end
        end
        DOWN_LOW: begin
          if (lit_q <= L_LOW_P1) begin
            lit_d   = L_LOW;
            state_d = UP_MID;
          end else begin
            lit_d = lit_q - 1'b1;
          end
        end
        UP_MID: begin
          if (lit_q >= L_MID_M1) begin
            lit_d   = L_MID;
            state_d = DOWN_ZERO;
          end else begin
            lit_d = lit_q + 1'b1;
          end
        end
        DOWN_ZERO, DOWN_END, KICK: begin
          if (lit_q <= L_ONE) begin
            lit_d = '0;
            unique case (state_q)
              DOWN_ZERO: state_d = UP_FULL2;
              DOWN_END:  state_d = IDLE;
              default:   state_d = ret_q;
            endcase
          end else begin
            lit_d = lit_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [BAR_MAX-1:0] bar;
  logic               unused_bar;

  assign bar        = lit_to_bar(7'(lit_q), mirror, N_LED);
  assign unused_bar = ^bar;

  assign LED           = bar[N_LED-1:0];
  assign current_state = state_q;
  assign current_index = lit_q;
  assign kick_count    = kick_q;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Directed bench for bound_flasher_param: default and 8-lamp builds.
// Scenario tasks check ramps, kickback, mirror, prescaler and reset.
module tb_bound_flasher_param;
  import bound_flasher_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, flick_a, mir_a;
  logic [15:0] led_a;
  logic [2:0]  st_a;
  logic [4:0]  idx_a;
  logic [7:0]  kc_a;

  logic        rst_b, flick_b, mir_b;
  logic [7:0]  led_b;
  logic [2:0]  st_b;
  logic [3:0]  idx_b;
  logic [7:0]  kc_b;

  int checks = 0;
  int errors = 0;

  bound_flasher_param dut_a (
    .clk(clk), .reset(rst_a), .flick(flick_a), .mirror(mir_a),
    .LED(led_a), .current_state(st_a), .current_index(idx_a),
    .kick_count(kc_a)
  );

  bound_flasher_param #(
    .N_LED(8), .LOW_BOUND(2), .MID_BOUND(6),
    .KICK_LO(3), .KICK_HI(6), .TICK_DIV(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .flick(flick_b), .mirror(mir_b),
    .LED(led_b), .current_state(st_b), .current_index(idx_b),
    .kick_count(kc_b)
  );

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_a();
    flick_a = 1'b1;
    adv(1);
    flick_a = 1'b0;
  endtask

  task automatic test_reset();
    adv(2);
    checks++;
    if (led_a !== 16'h0) begin
      errors++; $display("FAIL rst_led got %h exp 0000", led_a);
    end
    checks++;
    if (st_a !== IDLE) begin
      errors++; $display("FAIL rst_state got %0d exp 0", st_a);
    end
    checks++;
    if (idx_a !== 5'd0) begin
      errors++; $display("FAIL rst_idx got %0d exp 0", idx_a);
    end
    checks++;
    if (kc_a !== 8'd0) begin
      errors++; $display("FAIL rst_kick got %0d exp 0", kc_a);
    end
    rst_a = 1'b1;
    adv(1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && st_a !== IDLE; i++) adv(1);
    checks++;
    if (st_a !== IDLE) begin
      errors++; $display("FAIL %s_idle got %0d exp 0", nm, st_a);
    end
  endtask

  task automatic test_sequence();
    int        cs[8] = '{1, 16, 17, 27, 33, 44, 60, 76};
    int        cl[8] = '{1, 16, 15, 5, 11, 0, 16, 0};
    bf_state_t ct[8] = '{UP_FULL, DOWN_LOW, DOWN_LOW, UP_MID,
                         DOWN_ZERO, UP_FULL2, DOWN_END, IDLE};
    start_a();
    checks++;
    if (st_a !== UP_FULL || idx_a !== 5'd0) begin
      errors++;
      $display("FAIL seq_start st %0d idx %0d exp 1 0", st_a, idx_a);
    end
    for (int s = 1; s <= 77; s++) begin
      adv(1);
      for (int k = 0; k < 8; k++) begin
        if (cs[k] == s) begin
          checks++;
          if (idx_a !== 5'(cl[k]) || st_a !== ct[k]) begin
            errors++;
            $display("FAIL seq_step%0d st %0d idx %0d exp %0d %0d",
                     s, st_a, idx_a, ct[k], cl[k]);
          end
        end
      end
      if (s == 16) begin
        checks++;
        if (led_a !== 16'hFFFF) begin
          errors++; $display("FAIL seq_full_led got %h exp ffff", led_a);
        end
      end
      if (s == 27) begin
        checks++;
        if (led_a !== 16'h001F) begin
          errors++; $display("FAIL seq_low_led got %h exp 001f", led_a);
        end
      end
      if (s == 77) begin
        checks++;
        if (st_a !== IDLE || idx_a !== 5'd0) begin
          errors++;
          $display("FAIL seq_stay_idle st %0d idx %0d", st_a, idx_a);
        end
      end
    end
  endtask

  task automatic test_kick_full();
    start_a();
    adv(6);
    checks++;
    if (st_a !== UP_FULL || idx_a !== 5'd6) begin
      errors++; $display("FAIL kick_pre st %0d idx %0d", st_a, idx_a);
    end
    flick_a = 1'b1;
    adv(1);
    flick_a = 1'b0;
    checks++;
    if (st_a !== KICK || idx_a !== 5'd6 || kc_a !== 8'd1) begin
      errors++;
      $display("FAIL kick_enter st %0d idx %0d kc %0d exp 7 6 1",
               st_a, idx_a, kc_a);
    end
    adv(6);
    checks++;
    if (st_a !== UP_FULL || idx_a !== 5'd0) begin
      errors++;
      $display("FAIL kick_return st %0d idx %0d exp 1 0", st_a, idx_a);
    end
    adv(7);
    flick_a = 1'b1;
    adv(1);
    flick_a = 1'b0;
    checks++;
    if (st_a !== UP_FULL || idx_a !== 5'd8 || kc_a !== 8'd1) begin
      errors++;
      $display("FAIL kick_ignore st %0d idx %0d kc %0d exp 1 8 1",
               st_a, idx_a, kc_a);
    end
    wait_idle("kick");
  endtask

  task automatic test_kick_full2();
    start_a();
    adv(55);
    checks++;
    if (st_a !== UP_FULL2 || idx_a !== 5'd11) begin
      errors++; $display("FAIL k2_pre st %0d idx %0d", st_a, idx_a);
    end
    flick_a = 1'b1;
    adv(1);
    flick_a = 1'b0;
    checks++;
    if (st_a !== KICK || idx_a !== 5'd11 || kc_a !== 8'd2) begin
      errors++;
      $display("FAIL k2_enter st %0d idx %0d kc %0d exp 7 11 2",
               st_a, idx_a, kc_a);
    end
    adv(11);
    checks++;
    if (st_a !== UP_FULL2 || idx_a !== 5'd0) begin
      errors++;
      $display("FAIL k2_return st %0d idx %0d exp 5 0", st_a, idx_a);
    end
    adv(16);
    checks++;
    if (st_a !== DOWN_END || idx_a !== 5'd16) begin
      errors++;
      $display("FAIL k2_full st %0d idx %0d exp 6 16", st_a, idx_a);
    end
    adv(16);
    checks++;
    if (st_a !== IDLE || idx_a !== 5'd0) begin
      errors++;
      $display("FAIL k2_end st %0d idx %0d exp 0 0", st_a, idx_a);
    end
  endtask

  task automatic test_mirror();
    start_a();
    adv(30);
    checks++;
    if (st_a !== UP_MID || idx_a !== 5'd8 || led_a !== 16'h00FF) begin
      errors++;
      $display("FAIL mir_pre st %0d idx %0d led %h", st_a, idx_a, led_a);
    end
    mir_a = 1'b1;
    #1;
    checks++;
    if (led_a !== 16'hFF00) begin
      errors++; $display("FAIL mir_led got %h exp ff00", led_a);
    end
    checks++;
    if (st_a !== UP_MID || idx_a !== 5'd8) begin
      errors++; $display("FAIL mir_hold st %0d idx %0d", st_a, idx_a);
    end
    mir_a = 1'b0;
    adv(1);
    checks++;
    if (st_a !== UP_MID || idx_a !== 5'd9) begin
      errors++;
      $display("FAIL mir_next st %0d idx %0d exp 3 9", st_a, idx_a);
    end
    wait_idle("mir");
  endtask

  task automatic test_reset_mid();
    start_a();
    adv(40);
    checks++;
    if (st_a !== DOWN_ZERO || idx_a !== 5'd4) begin
      errors++; $display("FAIL rmid_pre st %0d idx %0d", st_a, idx_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (led_a !== 16'h0 || st_a !== IDLE) begin
      errors++;
      $display("FAIL rmid_async led %h st %0d exp 0 0", led_a, st_a);
    end
    checks++;
    if (idx_a !== 5'd0 || kc_a !== 8'd0) begin
      errors++;
      $display("FAIL rmid_clr idx %0d kc %0d exp 0 0", idx_a, kc_a);
    end
    adv(1);
    rst_a = 1'b1;
    adv(3);
    checks++;
    if (st_a !== IDLE || idx_a !== 5'd0) begin
      errors++; $display("FAIL rmid_idle st %0d idx %0d", st_a, idx_a);
    end
  endtask

  task automatic test_param8();
    int        cc[7] = '{35, 36, 60, 76, 100, 132, 164};
    int        cl[7] = '{7, 8, 2, 6, 0, 8, 0};
    bf_state_t ct[7] = '{UP_FULL, DOWN_LOW, UP_MID, DOWN_ZERO,
                         UP_FULL2, DOWN_END, IDLE};
    rst_b   = 1'b1;
    flick_b = 1'b1;
    adv(3);
    checks++;
    if (st_b !== IDLE) begin
      errors++; $display("FAIL p8_pretick st %0d exp 0", st_b);
    end
    adv(1);
    flick_b = 1'b0;
    checks++;
    if (st_b !== UP_FULL || idx_b !== 4'd0) begin
      errors++; $display("FAIL p8_start st %0d idx %0d", st_b, idx_b);
    end
    adv(3);
    checks++;
    if (idx_b !== 4'd0) begin
      errors++; $display("FAIL p8_hold idx %0d exp 0", idx_b);
    end
    adv(1);
    checks++;
    if (idx_b !== 4'd1) begin
      errors++; $display("FAIL p8_step1 idx %0d exp 1", idx_b);
    end
    for (int c = 9; c <= 164; c++) begin
      adv(1);
      for (int k = 0; k < 7; k++) begin
        if (cc[k] == c) begin
          checks++;
          if (idx_b !== 4'(cl[k]) || st_b !== ct[k]) begin
            errors++;
            $display("FAIL p8_clk%0d st %0d idx %0d exp %0d %0d",
                     c, st_b, idx_b, ct[k], cl[k]);
          end
        end
      end
      if (c == 36) begin
        checks++;
        if (led_b !== 8'hFF) begin
          errors++; $display("FAIL p8_led got %h exp ff", led_b);
        end
      end
    end
  endtask

  initial begin
    rst_a   = 1'b0;
    flick_a = 1'b0;
    mir_a   = 1'b0;
    rst_b   = 1'b0;
    flick_b = 1'b0;
    mir_b   = 1'b0;
    test_reset();
    test_sequence();
    test_kick_full();
    test_kick_full2();
    test_mirror();
    test_reset_mid();
    test_param8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
